// File: rtl/mips_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_t : arbiter sequencing states
//   arb_gnt_t   : which requester currently owns the memory port
//   mem_word_t  : 4 x 8-bit lane word, lane 0 = lowest byte address (MSB byte)
package mips_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } arb_gnt_t;

   typedef logic [0:3][7:0] mem_word_t;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter timing one memory access.
//   clk, rst_b  : clock, synchronous active-low reset
//   load_i      : load MEM_LATENCY (takes priority over dec_i)
//   dec_i       : decrement by one, saturating at zero
//   last_o      : count == 1 (final access cycle)
//   near_last_o : count == 2 (one cycle before the final access cycle)
module arb_lat_counter #(
   parameter int MEM_LATENCY = 4
) (
   input  logic clk,
   input  logic rst_b,
   input  logic load_i,
   input  logic dec_i,
   output logic last_o,
   output logic near_last_o
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   logic [CNT_W-1:0] count_q;

   // Latency count register
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         count_q <= {CNT_W{1'b0}};
      end else if (load_i) begin
         count_q <= CNT_W'(MEM_LATENCY);
      end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign last_o      = (count_q == CNT_W'(1));
   // Compared at 32 bits so a 1-bit counter (latency 1) never matches 2.
   assign near_last_o = (32'(count_q) == 32'd2);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the core's single byte-lane memory port.
// Data requests win over fetch; one access at a time, each lasting
// MEM_LATENCY cycles, followed by a one-cycle ack to the grantee.
//   if_req/if_addr          -> if_ack/if_rdata   : fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   : data requester
//   mem_addr/mem_data_out/mem_write_en, mem_data_in : memory port
//   halted : blocks new grants;  busy : access in flight (ACCESS or DONE)
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 if_req,
   input  logic [XLEN-1:0]      if_addr,
   output logic                 if_ack,
   output logic [0:3][7:0]      if_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [XLEN-1:0]      d_addr,
   input  logic [0:3][7:0]      d_wdata,
   output logic                 d_ack,
   output logic [0:3][7:0]      d_rdata,
   output logic [XLEN-1:0]      mem_addr,
   output logic [0:3][7:0]      mem_data_out,
   input  logic [0:3][7:0]      mem_data_in,
   output logic                 mem_write_en,
   input  logic                 halted,
   output logic                 busy
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   arb_state_t      state_q;
   arb_gnt_t        gnt_q;
   logic            we_q;
   logic [XLEN-1:0] mem_addr_q;
   mem_word_t       mem_data_out_q;
   mem_word_t       if_rdata_q;
   mem_word_t       d_rdata_q;
   logic            if_ack_q;
   logic            d_ack_q;
   logic            mem_write_en_q;
   logic            busy_q;

   logic            grant_s;
   arb_gnt_t        gnt_sel_s;
   logic            grant_we_s;
   logic [XLEN-1:0] grant_addr_s;
   logic            cnt_last_s;
   logic            cnt_near_last_s;

   // Grant decision: only in IDLE and not halted, data before fetch
   always_comb begin
      grant_s      = 1'b0;
      gnt_sel_s    = GNT_IF;
      grant_we_s   = 1'b0;
      grant_addr_s = if_addr & ALIGN_MASK;
      if ((state_q == ARB_IDLE) && !halted) begin
         if (d_req) begin
            grant_s      = 1'b1;
            gnt_sel_s    = GNT_D;
            grant_we_s   = d_we;
            grant_addr_s = d_addr & ALIGN_MASK;
         end else if (if_req) begin
            grant_s = 1'b1;
         end else begin
            grant_s = 1'b0;
         end
      end else begin
         grant_s = 1'b0;
      end
   end

   arb_lat_counter #(
      .MEM_LATENCY (MEM_LATENCY)
   ) u_lat_counter (
      .clk         (clk),
      .rst_b       (rst_b),
      .load_i      (grant_s),
      .dec_i       (state_q == ARB_ACCESS),
      .last_o      (cnt_last_s),
      .near_last_o (cnt_near_last_s)
   );

   // Arbitration FSM; every output is a register written here
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q        <= ARB_IDLE;
         gnt_q          <= GNT_IF;
         we_q           <= 1'b0;
         mem_addr_q     <= {XLEN{1'b0}};
         mem_data_out_q <= 32'h0000_0000;
         if_rdata_q     <= 32'h0000_0000;
         d_rdata_q      <= 32'h0000_0000;
         if_ack_q       <= 1'b0;
         d_ack_q        <= 1'b0;
         mem_write_en_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         // Pulsed outputs default low each cycle.
         if_ack_q       <= 1'b0;
         d_ack_q        <= 1'b0;
         mem_write_en_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (grant_s) begin
                  gnt_q          <= gnt_sel_s;
                  we_q           <= grant_we_s;
                  mem_addr_q     <= grant_addr_s;
                  mem_data_out_q <= d_wdata;
                  busy_q         <= 1'b1;
                  state_q        <= ARB_ACCESS;
                  // With a one-cycle access the first ACCESS cycle is also the last.
                  mem_write_en_q <= grant_we_s && (MEM_LATENCY == 1);
               end
            end
            ARB_ACCESS: begin
               // Strobe is registered, so it is raised one cycle ahead of the last.
               mem_write_en_q <= we_q && cnt_near_last_s;
               if (cnt_last_s) begin
                  state_q <= ARB_DONE;
                  if (gnt_q == GNT_D) begin
                     d_ack_q <= 1'b1;
                     if (!we_q) begin
                        d_rdata_q <= mem_data_in;
                     end
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_data_in;
                  end
               end
            end
            ARB_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ARB_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign if_ack       = if_ack_q;
   assign if_rdata     = if_rdata_q;
   assign d_ack        = d_ack_q;
   assign d_rdata      = d_rdata_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_out = mem_data_out_q;
   assign mem_write_en = mem_write_en_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a timeline model (grant cycle + latency)
// checks the L=4 instance every cycle; directed literal checks pin the
// model and exercise an L=1 instance.
module tb_mem_port_arbiter;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        if_req, d_req, d_we, halted;
   logic [31:0] if_addr, d_addr, d_wdata, mem_data_in;
   logic        if_ack, d_ack, mem_write_en, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_out;

   logic        u1_d_req, u1_d_we;
   logic [31:0] u1_d_addr, u1_d_wdata, u1_mem_data_in;
   logic        u1_if_ack, u1_d_ack, u1_mem_write_en, u1_busy;
   logic [31:0] u1_if_rdata, u1_d_rdata, u1_mem_addr, u1_mem_data_out;

   int n_vec = 0;
   int n_bad = 0;
   int tcur  = 0;
   int t0    = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst_b(rst_b),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_write_en(mem_write_en), .halted(halted), .busy(busy)
   );

   mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_b(rst_b),
      .if_req(1'b0), .if_addr(32'h0000_0000), .if_ack(u1_if_ack), .if_rdata(u1_if_rdata),
      .d_req(u1_d_req), .d_we(u1_d_we), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata),
      .d_ack(u1_d_ack), .d_rdata(u1_d_rdata),
      .mem_addr(u1_mem_addr), .mem_data_out(u1_mem_data_out), .mem_data_in(u1_mem_data_in),
      .mem_write_en(u1_mem_write_en), .halted(1'b0), .busy(u1_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, tcur);
      end
   endtask

   // Model: one access record described by its grant cycle
   logic        m_active = 1'b0;
   logic        m_d = 1'b0, m_we = 1'b0;
   int          m_start = 0;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_if_rd = 32'h0, m_d_rd = 32'h0;

   always @(posedge clk) begin
      if (!rst_b) begin
         m_active <= 1'b0;
         m_addr   <= 32'h0;
         m_wdata  <= 32'h0;
         m_if_rd  <= 32'h0;
         m_d_rd   <= 32'h0;
      end else if (!m_active) begin
         if (!halted && (d_req || if_req)) begin
            m_active <= 1'b1;
            m_start  <= tcur;
            m_d      <= d_req;
            m_we     <= d_req && d_we;
            m_addr   <= (d_req ? d_addr : if_addr) & ~32'h0000_0003;
            m_wdata  <= d_wdata;
         end
      end else begin
         if (tcur == m_start + L && !m_we) begin
            if (m_d) m_d_rd <= mem_data_in;
            else     m_if_rd <= mem_data_in;
         end
         if (tcur == m_start + L + 1) m_active <= 1'b0;
      end
      tcur <= tcur + 1;
   end

   // Per-cycle compare of the L=4 instance against the model
   always @(negedge clk) begin
      if (tcur > 0) begin
         chk("busy",         {31'b0, busy},         {31'b0, m_active});
         chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, m_active && m_we && (tcur == m_start + L)});
         chk("d_ack",        {31'b0, d_ack},        {31'b0, m_active && m_d && (tcur == m_start + L + 1)});
         chk("if_ack",       {31'b0, if_ack},       {31'b0, m_active && !m_d && (tcur == m_start + L + 1)});
         chk("mem_addr",     mem_addr,     m_addr);
         chk("mem_data_out", mem_data_out, m_wdata);
         chk("if_rdata",     if_rdata,     m_if_rd);
         chk("d_rdata",      d_rdata,      m_d_rd);
      end
   end

   task automatic at(input int n);
      while (tcur < t0 + n) @(negedge clk);
   endtask

   initial begin
      rst_b = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; halted = 1'b0;
      if_addr = 32'h40; d_addr = 32'h20; d_wdata = 32'h0; mem_data_in = 32'hA5A5_0F0F;
      u1_d_req = 1'b0; u1_d_we = 1'b0; u1_d_addr = 32'h0; u1_d_wdata = 32'h0;
      u1_mem_data_in = 32'h0;

      // Reset held for three cycles with both requests high
      t0 = 0;
      for (int k = 1; k <= 3; k++) begin
         at(k);
         chk("rst_busy", {31'b0, busy}, 32'h0);
         chk("rst_addr", mem_addr, 32'h0);
         chk("rst_ack",  {30'b0, if_ack, d_ack}, 32'h0);
      end
      rst_b = 1'b1; if_req = 1'b0;

      // First grant right after reset: load at 0x20
      t0 = tcur;
      at(1); chk("post_rst_busy", {31'b0, busy}, 32'h1); chk("post_rst_addr", mem_addr, 32'h20);
      at(5); chk("post_rst_dack", {31'b0, d_ack}, 32'h1); chk("post_rst_rdata", d_rdata, 32'hA5A5_0F0F);
      d_req = 1'b0;
      at(7);

      // Single fetch
      t0 = tcur; if_req = 1'b1; if_addr = 32'h40; mem_data_in = 32'h1122_3344;
      at(1); chk("f_addr1", mem_addr, 32'h40);
      at(4); chk("f_addr4", mem_addr, 32'h40); chk("f_we4", {31'b0, mem_write_en}, 32'h0);
      at(5); chk("f_ack", {31'b0, if_ack}, 32'h1); chk("f_rdata", if_rdata, 32'h1122_3344);
      chk("f_dack", {31'b0, d_ack}, 32'h0);
      if_req = 1'b0;
      at(7);

      // Simultaneous fetch and store: store first
      t0 = tcur; if_req = 1'b1; if_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; mem_data_in = 32'h5566_7788;
      at(3); chk("s_we3", {31'b0, mem_write_en}, 32'h0);
      at(4); chk("s_we4", {31'b0, mem_write_en}, 32'h1); chk("s_wdata", mem_data_out, 32'hDEAD_BEEF);
      chk("s_addr4", mem_addr, 32'h100);
      at(5); chk("s_dack", {31'b0, d_ack}, 32'h1); chk("s_we5", {31'b0, mem_write_en}, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      at(6); chk("s_idle6", {31'b0, busy}, 32'h0); chk("s_addr6", mem_addr, 32'h100);
      at(7); chk("s_fgrant", {31'b0, busy}, 32'h1); chk("s_faddr", mem_addr, 32'h0);
      at(11); chk("s_fack", {31'b0, if_ack}, 32'h1); chk("s_frdata", if_rdata, 32'h5566_7788);
      chk("s_drdata_kept", d_rdata, 32'hA5A5_0F0F);
      if_req = 1'b0;
      at(13);

      // Halt raised during a fetch; pending store waits
      t0 = tcur; if_req = 1'b1; if_addr = 32'h80; mem_data_in = 32'h99AA_BBCC;
      at(2); halted = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h0102_0304;
      at(5); chk("h_fack", {31'b0, if_ack}, 32'h1);
      if_req = 1'b0;
      for (int k = 6; k <= 10; k++) begin
         at(k);
         chk("h_busy", {31'b0, busy}, 32'h0);
         chk("h_we",   {31'b0, mem_write_en}, 32'h0);
         chk("h_dack", {31'b0, d_ack}, 32'h0);
      end
      halted = 1'b0;
      at(14); chk("h_we_after", {31'b0, mem_write_en}, 32'h1); chk("h_wdata", mem_data_out, 32'h0102_0304);
      at(15); chk("h_dack_after", {31'b0, d_ack}, 32'h1);
      d_req = 1'b0; d_we = 1'b0;
      at(17);

      // Reset in the middle of a store
      t0 = tcur; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFE_BABE;
      at(2); rst_b = 1'b0; d_req = 1'b0; d_we = 1'b0;
      at(3); chk("r_busy", {31'b0, busy}, 32'h0); chk("r_addr", mem_addr, 32'h0);
      chk("r_ifrd", if_rdata, 32'h0); chk("r_drd", d_rdata, 32'h0);
      rst_b = 1'b1;
      for (int k = 4; k <= 8; k++) begin
         at(k);
         chk("r_we",   {31'b0, mem_write_en}, 32'h0);
         chk("r_dack", {31'b0, d_ack}, 32'h0);
      end

      // Latency-1 instance: unaligned load, regrant, store
      t0 = tcur; u1_d_req = 1'b1; u1_d_we = 1'b0; u1_d_addr = 32'h103; u1_mem_data_in = 32'hCAFE_F00D;
      at(1); chk("l1_addr", u1_mem_addr, 32'h100); chk("l1_busy1", {31'b0, u1_busy}, 32'h1);
      chk("l1_we1", {31'b0, u1_mem_write_en}, 32'h0);
      at(2); chk("l1_dack", {31'b0, u1_d_ack}, 32'h1); chk("l1_rdata", u1_d_rdata, 32'hCAFE_F00D);
      u1_d_addr = 32'h204; u1_mem_data_in = 32'h1234_5678;
      at(3); chk("l1_idle3", {31'b0, u1_busy}, 32'h0); chk("l1_dack3", {31'b0, u1_d_ack}, 32'h0);
      at(4); chk("l1_busy4", {31'b0, u1_busy}, 32'h1); chk("l1_addr4", u1_mem_addr, 32'h204);
      at(5); chk("l1_dack5", {31'b0, u1_d_ack}, 32'h1); chk("l1_rdata5", u1_d_rdata, 32'h1234_5678);
      u1_d_we = 1'b1; u1_d_addr = 32'h308; u1_d_wdata = 32'h0BAD_C0DE;
      at(7); chk("l1_we7", {31'b0, u1_mem_write_en}, 32'h1); chk("l1_wdata7", u1_mem_data_out, 32'h0BAD_C0DE);
      chk("l1_addr7", u1_mem_addr, 32'h308);
      at(8); chk("l1_dack8", {31'b0, u1_d_ack}, 32'h1); chk("l1_we8", {31'b0, u1_mem_write_en}, 32'h0);
      chk("l1_rdata8", u1_d_rdata, 32'h1234_5678);
      u1_d_req = 1'b0; u1_d_we = 1'b0;
      at(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the core's single memory port. Fetch and data-access requesters share one byte-lane memory interface (4 × 8-bit lanes, word-addressed). The block grants one requester at a time, drives the memory address, write data and write strobe for a fixed access latency, and returns read data with a one-cycle acknowledge. It sits between the `data_path` fetch/load-store logic and the external memory port of `mips_core`.

## Interface
- `XLEN`, 32: address width.
- `MEM_LATENCY`, 4: cycles the memory needs per access; legal range 1..15.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst_b`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch request (read only).
- `if_addr`  in  XLEN  fetch address.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid in this cycle.
- `if_rdata`  out  8 × [0:3]  fetched word, lane 0 = lowest byte address.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  XLEN  data address.
- `d_wdata`  in  8 × [0:3]  store data.
- `d_ack`  out  1  one-cycle pulse; `d_rdata` is valid in this cycle (loads).
- `d_rdata`  out  8 × [0:3]  loaded word.
- `mem_addr`  out  XLEN  memory address, word-aligned.
- `mem_data_out`  out  8 × [0:3]  memory write data.
- `mem_data_in`  in  8 × [0:3]  memory read data.
- `mem_write_en`  out  1  memory write strobe.
- `halted`  in  1  core halted; no new grants while high.
- `busy`  out  1  high while an access is in flight (ACCESS or DONE).

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE behaviour:
  - `d_req` has priority over `if_req`.
  - On a grant (and `halted`=0), latch grantee, `d_we` (forced 0 for fetch), the address with bits [1:0] forced to 0, and `d_wdata`.
  - Load the latency counter with `MEM_LATENCY`, then go to ACCESS.
- ACCESS:
  - Counter decrements each cycle.
  - In the last cycle (counter==1), `mem_write_en`=1 if the access is a store.
  - At the end of that cycle, `mem_data_in` is registered into the grantee's rdata register. Loads only; fetch always loads.
  - Then go to DONE.
- DONE:
  - Grantee's ack=1 for exactly one cycle, then go to IDLE.
  - No grant is made in DONE.
- Requester rule: hold req until ack and drop it the cycle after ack.
  - Address and data changes after the grant are ignored, because they are latched.
  - Dropping req before ack does not abort the access: the access completes and ack still pulses.
- `halted`: checked only in IDLE. An in-flight access always completes.
- `if_rdata` and `d_rdata` hold their last value until overwritten by a later access of the same requester.
- Reset (any state, including mid-access):
  - Next cycle is IDLE.
  - All outputs are 0: `mem_addr`, `mem_data_out`, both rdata, both acks, `mem_write_en`, `busy`.
  - A store interrupted by reset never raises `mem_write_en`.

## Timing
- Request first sampled high in IDLE at cycle 0.
- `mem_addr` and `mem_data_out` are registered and valid in cycles 1..L, where L = `MEM_LATENCY`.
- `mem_write_en` is high in cycle L only.
- Memory read data is sampled at the end of cycle L.
- Ack is high in cycle L+1.
- The earliest next grant is decided in cycle L+2. Back-to-back period is L+2 cycles.
- Simultaneous `if_req` and `d_req`: data is served first. The fetch is granted in the IDLE cycle after the data DONE.
- `mem_addr` and `mem_data_out` hold their values through DONE and IDLE until the next grant.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds:
  - `arb_state_t` enum {ARB_IDLE, ARB_ACCESS, ARB_DONE}
  - `arb_gnt_t` enum {GNT_IF, GNT_D}
  - `mem_word_t` (4 × 8-bit lane array)
- One sub-module, `arb_lat_counter`: loadable down-counter with an `last` flag (count==1). Its width is derived from `MEM_LATENCY`.
- All remaining logic is in `mem_port_arbiter`.

## Test plan
- Reset: hold `rst_b`=0 for 3 cycles with both reqs high. Required: all outputs 0 and `busy`=0 throughout. The first grant is decided on the first cycle after `rst_b` rises.
- Single fetch, L=4: `if_addr`=0x40, memory returns {0x11,0x22,0x33,0x44}. Required: `mem_addr`=0x40 in cycles 1-4, `if_ack` in cycle 5 with that data, `d_ack`=0, `mem_write_en`=0.
- Simultaneous requests, L=4: `if_addr`=0x0, store at `d_addr`=0x100 with `d_wdata`={0xDE,0xAD,0xBE,0xEF}. Required:
  - `mem_write_en` high in cycle 4 only, with `mem_data_out`=that data.
  - `d_ack` in cycle 5.
  - Fetch granted cycle 6, `if_ack` in cycle 11.
- Halt: raise `halted` in cycle 2 of a fetch access, then assert `d_req`. Required: fetch acks in cycle 5; `d_req` is never granted; `mem_write_en` stays 0; `busy`=0 from cycle 6.
- Reset mid-store: assert `rst_b`=0 in cycle 2 of a store. Required: `mem_write_en` never rises, no `d_ack`, IDLE next cycle.
- Unaligned and L=1: load at `d_addr`=0x103 with `MEM_LATENCY`=1. Required: `mem_addr`=0x100 in cycle 1, `d_ack` in cycle 2, next grant possible in cycle 3.
